// File: rtl/dlbf_coeffs_cdc_rx_if.sv
// Handshake, data and done-level bundle for the DLBF coefficient CDC receiver.
// master = foreign/source side and control inputs, slave = the receiver.
interface dlbf_coeffs_cdc_rx_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 16
);
   logic [NUM_CH-1:0]        src_req;
   logic [NUM_CH*DATA_W-1:0] src_data;
   logic [NUM_CH-1:0]        dst_ack;
   logic [NUM_CH*DATA_W-1:0] cfg_data;
   logic [NUM_CH-1:0]        cfg_valid;
   logic [NUM_CH-1:0]        done_async;
   logic [NUM_CH-1:0]        done_mask;
   logic [NUM_CH-1:0]        done_sync;
   logic                     all_done;
   logic                     irq_clr;
   logic                     irq;
   logic [NUM_CH-1:0]        err;

   modport master (
      output src_req, src_data, done_async, done_mask, irq_clr,
      input  dst_ack, cfg_data, cfg_valid, done_sync, all_done, irq, err
   );

   modport slave (
      input  src_req, src_data, done_async, done_mask, irq_clr,
      output dst_ack, cfg_data, cfg_valid, done_sync, all_done, irq, err
   );
endinterface

// File: rtl/dlbf_coeffs_cdc_rx.sv
// Destination-side CDC receiver: per-channel 4-phase req/ack capture plus synchronised done aggregation.
// Optional ACK watchdog enabled by defining DLBF_COEFFS_CDC_RX_TIMEOUT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | ack low, waiting for synchronised req to rise
// ST_ACK    | word captured, ack high, waiting for req to fall
// ST_WAIT   | (watchdog only) timed out, ack low, waiting for req to fall
module dlbf_coeffs_cdc_rx #(
   parameter int NUM_CH      = 4,
   parameter int DATA_W      = 16,
   parameter int SYNC_FF     = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input logic                 m_axis_clk,
   input logic                 m_axis_aresetn,
   dlbf_coeffs_cdc_rx_if.slave bus
);

   if (NUM_CH < 1 || NUM_CH > 16 || DATA_W < 1 || DATA_W > 32 ||
       SYNC_FF < 2 || SYNC_FF > 10 || TIMEOUT_CYC < 1) begin : g_param_chk
      $error("dlbf_coeffs_cdc_rx: parameter out of range");
   end

`ifdef DLBF_COEFFS_CDC_RX_TIMEOUT_EN
   typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_WAIT} state_t;
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
`else
   typedef enum logic [1:0] {ST_IDLE, ST_ACK} state_t;
`endif

   // Asynchronous assert, synchronous release of the internal reset.
   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst_int_n;

   assign rst_sync_d = {rst_sync_q[0], 1'b1};

   always_ff @(posedge m_axis_clk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) rst_sync_q <= '0;
      else                 rst_sync_q <= rst_sync_d;
   end

   assign rst_int_n = rst_sync_q[1];

   logic [SYNC_FF-1:0][NUM_CH-1:0] req_ff_q, req_ff_d;
   logic [SYNC_FF-1:0][NUM_CH-1:0] done_ff_q, done_ff_d;
   logic [NUM_CH-1:0]              req_s;
   logic [NUM_CH-1:0][DATA_W-1:0]  src_w;

   state_t                        state_q [NUM_CH];
   state_t                        state_d [NUM_CH];
   logic [NUM_CH-1:0]             ack_q, ack_d;
   logic [NUM_CH-1:0]             valid_q, valid_d;
   logic [NUM_CH-1:0][DATA_W-1:0] data_q, data_d;
   logic                          all_done_q, all_done_d;
   logic                          all_done_dly_q;
   logic                          irq_q, irq_d;
`ifdef DLBF_COEFFS_CDC_RX_TIMEOUT_EN
   logic [CW-1:0]                 cnt_q [NUM_CH];
   logic [CW-1:0]                 cnt_d [NUM_CH];
   logic [NUM_CH-1:0]             err_q, err_d;
`endif

   assign src_w     = bus.src_data;
   assign req_ff_d  = {req_ff_q[SYNC_FF-2:0], bus.src_req};
   assign done_ff_d = {done_ff_q[SYNC_FF-2:0], bus.done_async};
   assign req_s     = req_ff_q[SYNC_FF-1];

   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      valid_d = '0;
      data_d  = data_q;
`ifdef DLBF_COEFFS_CDC_RX_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
         case (state_q[i])
            ST_IDLE: begin
               if (req_s[i]) begin
                  state_d[i] = ST_ACK;
                  ack_d[i]   = 1'b1;
                  valid_d[i] = 1'b1;
                  data_d[i]  = src_w[i];
`ifdef DLBF_COEFFS_CDC_RX_TIMEOUT_EN
                  cnt_d[i]   = '0;
`endif
               end
            end
            ST_ACK: begin
               if (!req_s[i]) begin
                  state_d[i] = ST_IDLE;
                  ack_d[i]   = 1'b0;
               end
`ifdef DLBF_COEFFS_CDC_RX_TIMEOUT_EN
               else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
                  if (cnt_d[i] == CW'(TIMEOUT_CYC)) begin
                     state_d[i] = ST_WAIT;
                     ack_d[i]   = 1'b0;
                     err_d[i]   = 1'b1;
                  end
               end
`endif
            end
`ifdef DLBF_COEFFS_CDC_RX_TIMEOUT_EN
            ST_WAIT: begin
               if (!req_s[i]) state_d[i] = ST_IDLE;
            end
`endif
            default: begin
               state_d[i] = ST_IDLE;
               ack_d[i]   = 1'b0;
            end
         endcase
      end
   end

   // An all-zero mask must never report done.
   assign all_done_d = (|bus.done_mask) & (&(done_ff_q[SYNC_FF-1] | ~bus.done_mask));
   assign irq_d      = (all_done_q & ~all_done_dly_q) | (irq_q & ~bus.irq_clr);

   always_ff @(posedge m_axis_clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         req_ff_q       <= '0;
         done_ff_q      <= '0;
         ack_q          <= '0;
         valid_q        <= '0;
         data_q         <= '0;
         all_done_q     <= 1'b0;
         all_done_dly_q <= 1'b0;
         irq_q          <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) state_q[i] <= ST_IDLE;
`ifdef DLBF_COEFFS_CDC_RX_TIMEOUT_EN
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
         err_q          <= '0;
`endif
      end else begin
         req_ff_q       <= req_ff_d;
         done_ff_q      <= done_ff_d;
         ack_q          <= ack_d;
         valid_q        <= valid_d;
         data_q         <= data_d;
         all_done_q     <= all_done_d;
         all_done_dly_q <= all_done_q;
         irq_q          <= irq_d;
         state_q        <= state_d;
`ifdef DLBF_COEFFS_CDC_RX_TIMEOUT_EN
         cnt_q          <= cnt_d;
         err_q          <= err_d;
`endif
      end
   end

   assign bus.dst_ack   = ack_q;
   assign bus.cfg_valid = valid_q;
   assign bus.cfg_data  = data_q;
   assign bus.done_sync = done_ff_q[SYNC_FF-1];
   assign bus.all_done  = all_done_q;
   assign bus.irq       = irq_q;
`ifdef DLBF_COEFFS_CDC_RX_TIMEOUT_EN
   assign bus.err       = err_q;
`else
   assign bus.err       = '0;
`endif

endmodule

// File: tb/tb_dlbf_coeffs_cdc_rx.sv
// Directed bench for dlbf_coeffs_cdc_rx (NUM_CH=4, DATA_W=16, SYNC_FF=4) with a per-channel capture scoreboard.
module tb_dlbf_coeffs_cdc_rx;
   localparam int NCH = 4;
   localparam int DW  = 16;
   localparam int SFF = 4;

   logic m_axis_clk = 1'b0;
   logic m_axis_aresetn = 1'b1;
   int   n_checks = 0;
   int   n_err = 0;
   logic [DW-1:0] exp_q [NCH][$];

   always #5 m_axis_clk = ~m_axis_clk;

   dlbf_coeffs_cdc_rx_if #(.NUM_CH(NCH), .DATA_W(DW)) bus_if ();

   dlbf_coeffs_cdc_rx #(.NUM_CH(NCH), .DATA_W(DW), .SYNC_FF(SFF), .TIMEOUT_CYC(16)) dut (
      .m_axis_clk     (m_axis_clk),
      .m_axis_aresetn (m_axis_aresetn),
      .bus            (bus_if)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Step to just after the n-th following active edge.
   task automatic edges(input int n);
      repeat (n) @(posedge m_axis_clk);
      #1;
   endtask

   task automatic drive_slot();
      @(posedge m_axis_clk);
      #2;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ack"},   64'(bus_if.dst_ack),   64'h0);
      check({tag, "_valid"}, 64'(bus_if.cfg_valid), 64'h0);
      check({tag, "_data"},  64'(bus_if.cfg_data),  64'h0);
      check({tag, "_dsync"}, 64'(bus_if.done_sync), 64'h0);
      check({tag, "_alld"},  64'(bus_if.all_done),  64'h0);
      check({tag, "_irq"},   64'(bus_if.irq),       64'h0);
      check({tag, "_err"},   64'(bus_if.err),       64'h0);
   endtask

   // Scoreboard: every capture pulse must match the oldest expected word of that channel.
   always @(negedge m_axis_clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (bus_if.cfg_valid[c] === 1'b1) begin
            if (exp_q[c].size() == 0) begin
               check($sformatf("unexpected_cap_ch%0d", c), 64'(bus_if.cfg_valid[c]), 64'h0);
            end else begin
               check($sformatf("cap_ch%0d", c), 64'(bus_if.cfg_data[c*DW +: DW]), 64'(exp_q[c].pop_front()));
            end
         end
      end
   end

   initial begin
      logic [NCH*DW-1:0] word;
      bit found;
      bus_if.src_req    = '0;
      bus_if.src_data   = '0;
      bus_if.done_async = '0;
      bus_if.done_mask  = '0;
      bus_if.irq_clr    = 1'b0;

      #2 m_axis_aresetn = 1'b0;
      edges(3);
      check_all_zero("reset");
      drive_slot();
      m_axis_aresetn = 1'b1;
      edges(6);

      // Single channel handshake, exact latency
      drive_slot();
      bus_if.src_data[2*DW +: DW] = 16'hA5C3;
      exp_q[2].push_back(16'hA5C3);
      bus_if.src_req[2] = 1'b1;
      edges(SFF);
      check("t1_ack_early", 64'(bus_if.dst_ack), 64'h0);
      edges(1);
      check("t1_valid", 64'(bus_if.cfg_valid), 64'h4);
      check("t1_ack", 64'(bus_if.dst_ack), 64'h4);
      check("t1_data", 64'(bus_if.cfg_data[2*DW +: DW]), 64'hA5C3);
      edges(1);
      check("t1_valid_pulse", 64'(bus_if.cfg_valid), 64'h0);
      drive_slot();
      bus_if.src_req[2] = 1'b0;
      edges(SFF);
      check("t1_ack_hold", 64'(bus_if.dst_ack), 64'h4);
      edges(1);
      check("t1_ack_fall", 64'(bus_if.dst_ack), 64'h0);
      check("t1_data_held", 64'(bus_if.cfg_data[2*DW +: DW]), 64'hA5C3);
      edges(3);

      // All channels at once, then a second word per channel
      for (int round = 0; round < 2; round++) begin
         drive_slot();
         for (int c = 0; c < NCH; c++) begin
            bus_if.src_data[c*DW +: DW] = DW'(round*4 + c + 1);
            exp_q[c].push_back(DW'(round*4 + c + 1));
         end
         bus_if.src_req = '1;
         edges(SFF + 1);
         check($sformatf("t2_valid_r%0d", round), 64'(bus_if.cfg_valid), 64'hF);
         check($sformatf("t2_ack_r%0d", round), 64'(bus_if.dst_ack), 64'hF);
         drive_slot();
         bus_if.src_req = '0;
         edges(SFF + 3);
         check($sformatf("t2_ack_low_r%0d", round), 64'(bus_if.dst_ack), 64'h0);
      end
      word = {16'd8, 16'd7, 16'd6, 16'd5};
      check("t2_words", 64'(bus_if.cfg_data), 64'(word));

      // Masked done aggregation and irq
      drive_slot();
      bus_if.done_mask  = 4'b1011;
      bus_if.done_async = 4'b1011;
      edges(SFF);
      check("t3_done_sync", 64'(bus_if.done_sync), 64'hB);
      check("t3_alld_early", 64'(bus_if.all_done), 64'h0);
      edges(1);
      check("t3_alld", 64'(bus_if.all_done), 64'h1);
      check("t3_irq_early", 64'(bus_if.irq), 64'h0);
      edges(1);
      check("t3_irq", 64'(bus_if.irq), 64'h1);
      edges(2);
      check("t3_irq_sticky", 64'(bus_if.irq), 64'h1);
      drive_slot();
      bus_if.irq_clr = 1'b1;
      edges(1);
      check("t3_irq_clr", 64'(bus_if.irq), 64'h0);
      bus_if.irq_clr = 1'b0;
      bus_if.done_mask = 4'b0000;
      edges(1);
      check("t3_mask0", 64'(bus_if.all_done), 64'h0);
      edges(2);
      check("t3_mask0_hold", 64'(bus_if.all_done), 64'h0);
      check("t3_irq_idle", 64'(bus_if.irq), 64'h0);

      // irq_clr colliding with a new all_done rise: set wins
      drive_slot();
      bus_if.done_mask = 4'b1011;
      edges(2);
      check("t4_irq_set", 64'(bus_if.irq), 64'h1);
      bus_if.done_mask = 4'b0000;
      edges(2);
      check("t4_alld_low", 64'(bus_if.all_done), 64'h0);
      drive_slot();
      bus_if.done_mask = 4'b1011;
      edges(1);
      bus_if.irq_clr = 1'b1;
      edges(1);
      check("t4_set_wins", 64'(bus_if.irq), 64'h1);
      edges(1);
      check("t4_clr_alone", 64'(bus_if.irq), 64'h0);
      bus_if.irq_clr = 1'b0;
      edges(1);

      // Reset in the middle of a handshake
      drive_slot();
      bus_if.src_data[1*DW +: DW] = 16'h1234;
      exp_q[1].push_back(16'h1234);
      bus_if.src_req[1] = 1'b1;
      edges(SFF + 2);
      check("t5_in_ack", 64'(bus_if.dst_ack), 64'h2);
      check("t5_alld_pre", 64'(bus_if.all_done), 64'h1);
      #2 m_axis_aresetn = 1'b0;
      exp_q[1].push_back(16'h1234);
      #1;
      check_all_zero("t5_rst");
      edges(2);
      drive_slot();
      m_axis_aresetn = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         edges(1);
         if (bus_if.cfg_valid[1] === 1'b1) found = 1'b1;
      end
      check("t5_recapture", 64'(found), 64'h1);
      check("t5_ack_again", 64'(bus_if.dst_ack), 64'h2);
      drive_slot();
      bus_if.src_req = '0;
      edges(SFF + 3);
      check("t5_ack_low", 64'(bus_if.dst_ack), 64'h0);

      for (int c = 0; c < NCH; c++)
         check($sformatf("sb_empty_ch%0d", c), 64'(exp_q[c].size()), 64'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
